// File: rtl/mem_arbiter.sv
// mem_arbiter: single-port memory arbiter between fetch and memory stages with starvation guard and flush drain
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instrReq,
  input  logic [15:0] instrAddr,
  output logic        instrDone,
  output logic [15:0] instrData,
  input  logic        dataReq,
  input  logic        dataWr,
  input  logic [15:0] dataAddr,
  input  logic [15:0] dataIn,
  output logic        dataDone,
  output logic [15:0] dataOut,
  input  logic        flush,
  output logic        memEn,
  output logic        memWr,
  output logic [15:0] memAddr,
  output logic [15:0] memDataIn,
  input  logic [15:0] memDataOut,
  input  logic        memDone,
  output logic        stallFetch,
  output logic        stallMem,
  output logic        err
);
  typedef enum logic [1:0] {IDLE, DATA, INSTR, DRAIN} state_t;
  state_t state, nextState;
  logic issued;
  logic [3:0] starveCnt;
  logic instrElig, grantData, grantInstr, starved;
  assign instrElig = instrReq & ~flush;
  assign starved = starveCnt == 4'(STARVE_LIMIT);
  assign grantData = dataReq & ~(instrElig & starved);
  assign grantInstr = instrElig & ~grantData;
  assign memEn = (state == DATA || state == INSTR) && !issued;
  assign dataDone = state == DATA && memDone;
  assign instrDone = state == INSTR && memDone && !flush;
  assign dataOut = memDataOut;
  assign instrData = memDataOut;
  assign stallFetch = instrReq & ~instrDone;
  assign stallMem = dataReq & ~dataDone;
  always_comb begin
    nextState = state;
    unique case (state)
      IDLE:  nextState = grantData ? DATA : grantInstr ? INSTR : IDLE;
      DATA:  nextState = memDone ? IDLE : DATA;
      INSTR: nextState = memDone ? IDLE : flush ? DRAIN : INSTR;
      DRAIN: nextState = memDone ? IDLE : DRAIN;
      default: nextState = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      issued <= 1'b0;
      starveCnt <= 4'd0;
      err <= 1'b0;
      memAddr <= 16'd0;
      memDataIn <= 16'd0;
      memWr <= 1'b0;
    end else begin
      state <= nextState;
      issued <= state != IDLE;
      err <= err | (state == IDLE && memDone);
      if (state == IDLE) begin
        if (grantData || grantInstr) begin
          memAddr <= grantData ? dataAddr : instrAddr;
          memWr <= grantData & dataWr;
        end
        if (grantData) memDataIn <= dataIn;
        starveCnt <= (grantData && instrReq) ? (starved ? starveCnt : starveCnt + 4'd1)
                   : (grantInstr || !instrReq) ? 4'd0 : starveCnt;
      end
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenario tests for mem_arbiter with hand-computed expectations
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic rst, instrReq, dataReq, dataWr, flush, memDone;
  logic [15:0] instrAddr, dataAddr, dataIn, memDataOut;
  logic instrDone, dataDone, memEn, memWr, stallFetch, stallMem, err;
  logic [15:0] instrData, dataOut, memAddr, memDataIn;
  int vecs = 0;
  int errs = 0;

  mem_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .instrReq(instrReq), .instrAddr(instrAddr), .instrDone(instrDone), .instrData(instrData),
    .dataReq(dataReq), .dataWr(dataWr), .dataAddr(dataAddr), .dataIn(dataIn),
    .dataDone(dataDone), .dataOut(dataOut), .flush(flush),
    .memEn(memEn), .memWr(memWr), .memAddr(memAddr), .memDataIn(memDataIn),
    .memDataOut(memDataOut), .memDone(memDone),
    .stallFetch(stallFetch), .stallMem(stallMem), .err(err)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    @(negedge clk);
    rst = 1; instrReq = 1; dataReq = 1;
    @(negedge clk); #1;
    vecs++;
    if ({memEn, instrDone, dataDone, err} !== 4'b0000) begin
      errs++; $display("FAIL reset_strobes got %b want 0000", {memEn, instrDone, dataDone, err});
    end
    vecs++;
    if ({stallFetch, stallMem} !== 2'b11) begin
      errs++; $display("FAIL reset_stalls got %b want 11", {stallFetch, stallMem});
    end
    vecs++;
    if ({memWr, memAddr, memDataIn} !== 33'd0) begin
      errs++; $display("FAIL reset_latches got %h want 0", {memWr, memAddr, memDataIn});
    end
    rst = 0; instrReq = 0; dataReq = 0;
  endtask

  task automatic test_data_read();
    @(negedge clk);
    dataReq = 1; dataWr = 0; dataAddr = 16'h0040; #1;
    vecs++;
    if ({memEn, stallMem} !== 2'b01) begin
      errs++; $display("FAIL rd_idle got %b want 01", {memEn, stallMem});
    end
    @(negedge clk); #1;
    vecs++;
    if ({memEn, memWr, memAddr, dataDone, stallMem} !== {1'b1, 1'b0, 16'h0040, 1'b0, 1'b1}) begin
      errs++; $display("FAIL rd_issue got %h want %h", {memEn, memWr, memAddr, dataDone, stallMem},
                       {1'b1, 1'b0, 16'h0040, 1'b0, 1'b1});
    end
    @(negedge clk);
    memDone = 1; memDataOut = 16'hBEEF; #1;
    vecs++;
    if ({memEn, dataDone, dataOut, stallMem} !== {1'b0, 1'b1, 16'hBEEF, 1'b0}) begin
      errs++; $display("FAIL rd_done got %h want %h", {memEn, dataDone, dataOut, stallMem},
                       {1'b0, 1'b1, 16'hBEEF, 1'b0});
    end
    @(negedge clk);
    dataReq = 0; memDone = 0; #1;
    vecs++;
    if ({memEn, dataDone, err} !== 3'b000) begin
      errs++; $display("FAIL rd_after got %b want 000", {memEn, dataDone, err});
    end
  endtask

  task automatic test_both();
    @(negedge clk);
    instrReq = 1; instrAddr = 16'h0002;
    dataReq = 1; dataWr = 1; dataAddr = 16'h0100; dataIn = 16'h1234;
    @(negedge clk); #1;
    vecs++;
    if ({memEn, memWr, memAddr, memDataIn, instrDone} !== {1'b1, 1'b1, 16'h0100, 16'h1234, 1'b0}) begin
      errs++; $display("FAIL both_data_issue got %h want %h", {memEn, memWr, memAddr, memDataIn, instrDone},
                       {1'b1, 1'b1, 16'h0100, 16'h1234, 1'b0});
    end
    memDone = 1; #1;
    vecs++;
    if ({dataDone, instrDone, stallFetch} !== 3'b101) begin
      errs++; $display("FAIL both_data_done got %b want 101", {dataDone, instrDone, stallFetch});
    end
    @(negedge clk);
    dataReq = 0; memDone = 0;
    @(negedge clk); #1;
    vecs++;
    if ({memEn, memWr, memAddr} !== {1'b1, 1'b0, 16'h0002}) begin
      errs++; $display("FAIL both_instr_issue got %h want %h", {memEn, memWr, memAddr}, {1'b1, 1'b0, 16'h0002});
    end
    memDone = 1; memDataOut = 16'hABCD; #1;
    vecs++;
    if ({instrDone, instrData, stallFetch} !== {1'b1, 16'hABCD, 1'b0}) begin
      errs++; $display("FAIL both_instr_done got %h want %h", {instrDone, instrData, stallFetch}, {1'b1, 16'hABCD, 1'b0});
    end
    @(negedge clk);
    instrReq = 0; memDone = 0;
  endtask

  task automatic test_starve();
    @(negedge clk);
    instrReq = 1; instrAddr = 16'h0010;
    dataReq = 1; dataWr = 0; dataAddr = 16'h0200;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      memDone = 1; memDataOut = 16'(i); #1;
      vecs++;
      if ({memEn, memAddr, dataDone, instrDone} !==
          {1'b1, (i < 4) ? 16'h0200 : 16'h0010, i < 4, i == 4}) begin
        errs++; $display("FAIL starve_grant%0d got %h want %h", i, {memEn, memAddr, dataDone, instrDone},
                         {1'b1, (i < 4) ? 16'h0200 : 16'h0010, i < 4, i == 4});
      end
      @(negedge clk);
      memDone = 0;
    end
    #1;
    vecs++;
    if (dut.starveCnt !== 4'd0) begin
      errs++; $display("FAIL starve_cnt_clear got %0d want 0", dut.starveCnt);
    end
    instrReq = 0;
    @(negedge clk); #1;
    vecs++;
    if ({memEn, memAddr} !== {1'b1, 16'h0200}) begin
      errs++; $display("FAIL starve_after got %h want %h", {memEn, memAddr}, {1'b1, 16'h0200});
    end
    memDone = 1;
    @(negedge clk);
    dataReq = 0; memDone = 0;
  endtask

  task automatic test_flush();
    @(negedge clk);
    instrReq = 1; instrAddr = 16'h0030;
    @(negedge clk); #1;
    vecs++;
    if ({memEn, memWr, memAddr} !== {1'b1, 1'b0, 16'h0030}) begin
      errs++; $display("FAIL flush_issue got %h want %h", {memEn, memWr, memAddr}, {1'b1, 1'b0, 16'h0030});
    end
    dataReq = 1; dataWr = 0; dataAddr = 16'h0300;
    @(negedge clk);
    flush = 1; #1;
    vecs++;
    if ({memEn, instrDone} !== 2'b00) begin
      errs++; $display("FAIL flush_pulse got %b want 00", {memEn, instrDone});
    end
    @(negedge clk);
    flush = 0; instrReq = 0; #1;
    vecs++;
    if ({memEn, instrDone, dataDone} !== 3'b000) begin
      errs++; $display("FAIL flush_drain got %b want 000", {memEn, instrDone, dataDone});
    end
    @(negedge clk);
    memDone = 1; memDataOut = 16'hDEAD; #1;
    vecs++;
    if ({memEn, instrDone, dataDone} !== 3'b000) begin
      errs++; $display("FAIL flush_drain_done got %b want 000", {memEn, instrDone, dataDone});
    end
    @(negedge clk);
    memDone = 0; #1;
    vecs++;
    if ({memEn, err} !== 2'b00) begin
      errs++; $display("FAIL flush_idle got %b want 00", {memEn, err});
    end
    @(negedge clk);
    memDone = 1; memDataOut = 16'h7777; #1;
    vecs++;
    if ({memEn, memAddr, dataDone, dataOut} !== {1'b1, 16'h0300, 1'b1, 16'h7777}) begin
      errs++; $display("FAIL flush_data_next got %h want %h", {memEn, memAddr, dataDone, dataOut},
                       {1'b1, 16'h0300, 1'b1, 16'h7777});
    end
    @(negedge clk);
    dataReq = 0; memDone = 0;
  endtask

  task automatic test_err();
    @(negedge clk);
    memDone = 1; #1;
    vecs++;
    if ({err, dataDone, instrDone} !== 3'b000) begin
      errs++; $display("FAIL err_before got %b want 000", {err, dataDone, instrDone});
    end
    @(negedge clk);
    memDone = 0; #1;
    vecs++;
    if ({err, memEn} !== 2'b10) begin
      errs++; $display("FAIL err_set got %b want 10", {err, memEn});
    end
    dataReq = 1; dataWr = 1; dataAddr = 16'h0400; dataIn = 16'h5A5A;
    @(negedge clk);
    memDone = 1;
    @(negedge clk);
    dataReq = 0; memDone = 0; #1;
    vecs++;
    if (err !== 1'b1) begin
      errs++; $display("FAIL err_sticky got %b want 1", err);
    end
    rst = 1;
    @(negedge clk); #1;
    vecs++;
    if (err !== 1'b0) begin
      errs++; $display("FAIL err_clear got %b want 0", err);
    end
    rst = 0;
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    dataReq = 1; dataWr = 0; dataAddr = 16'h0500;
    @(negedge clk); #1;
    vecs++;
    if ({memEn, memAddr} !== {1'b1, 16'h0500}) begin
      errs++; $display("FAIL rstmid_issue got %h want %h", {memEn, memAddr}, {1'b1, 16'h0500});
    end
    rst = 1;
    @(negedge clk); #1;
    vecs++;
    if ({memEn, dataDone, memAddr} !== {1'b0, 1'b0, 16'h0000}) begin
      errs++; $display("FAIL rstmid_abandon got %h want 0", {memEn, dataDone, memAddr});
    end
    rst = 0;
    @(negedge clk);
    memDone = 1; memDataOut = 16'h5555; #1;
    vecs++;
    if ({memEn, memAddr, dataDone, dataOut} !== {1'b1, 16'h0500, 1'b1, 16'h5555}) begin
      errs++; $display("FAIL rstmid_retry got %h want %h", {memEn, memAddr, dataDone, dataOut},
                       {1'b1, 16'h0500, 1'b1, 16'h5555});
    end
    @(negedge clk);
    dataReq = 0; memDone = 0; #1;
    vecs++;
    if ({memEn, dataDone, err} !== 3'b000) begin
      errs++; $display("FAIL rstmid_idle got %b want 000", {memEn, dataDone, err});
    end
  endtask

  initial begin
    rst = 1; instrReq = 0; dataReq = 0; dataWr = 0; flush = 0; memDone = 0;
    instrAddr = 0; dataAddr = 0; dataIn = 0; memDataOut = 0;
    test_reset();
    test_data_read();
    test_both();
    test_starve();
    test_flush();
    test_err();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
